// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
// Holds the machine widths, the fetch state encoding and the queue entry layout.
package instruction_fetch_unit_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Canonical RISC-V no-op (addi x0, x0, 0).
    localparam logic [ILEN-1:0] NOP = 32'h00000013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instruction;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of {pc, instruction} between fetch and decode.
// Flush empties it in one cycle; the head reads as all-zero while empty.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         enq,
    input  fetch_entry_t enq_entry,
    input  logic         deq,
    output logic         valid,
    output logic         full,
    output fetch_entry_t head
);

    fetch_entry_t slots [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_enq;
    logic         do_deq;

    assign valid  = (count != 2'd0);
    assign full   = (count == 2'd2);
    assign do_deq = deq && valid;
    // A full queue still accepts a word in the same cycle its head leaves.
    assign do_enq = enq && (!full || do_deq);
    assign head   = valid ? slots[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (do_enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_deq) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_enq, do_deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            slots[wr_ptr] <= enq_entry;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch: walks the PC word by word into a 2-entry queue,
// halts past the end of instruction memory, and restarts on a branch redirect.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [63:0] MEM_LIMIT = 64'd96
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] inst_address,
    input  logic [ILEN-1:0] instruction_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instruction,
    output logic            misaligned_err
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic            enq;
    logic            deq;
    logic            flush;
    logic            q_valid;
    logic            q_full;
    fetch_entry_t    enq_entry;
    fetch_entry_t    head;

    assign inst_address    = pc;
    assign deq             = q_valid && out_ready;
    assign enq_entry       = '{pc: pc, instruction: instruction_in};
    assign out_valid       = q_valid;
    assign out_pc          = head.pc;
    assign out_instruction = head.instruction;

    fetch_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq       (enq),
        .enq_entry (enq_entry),
        .deq       (deq),
        .valid     (q_valid),
        .full      (q_full),
        .head      (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect outranks everything; the queue's flush also swallows any dequeue.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        enq        = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush      = 1'b1;
            pc_next    = align_word(redirect_pc);
            state_next = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (pc >= MEM_LIMIT) begin
                        state_next = HALT;
                    end else if (!q_full || deq) begin
                        enq     = 1'b1;
                        pc_next = pc + 64'd4;
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misaligned_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference of the fetch rules.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [63:0] LIMIT  = 64'd96;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] inst_address;
    logic [31:0] instruction_in;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instruction;
    logic        misaligned_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:31];

    always #5 clk = ~clk;

    always_comb instruction_in = (inst_address < 64'd128) ? mem[inst_address[6:2]] : NOP;

    instruction_fetch_unit #(
        .RESET_PC  (RST_PC),
        .MEM_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_address    (inst_address),
        .instruction_in  (instruction_in),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .misaligned_err  (misaligned_err)
    );

    // Reference model: a plain queue of fetched words plus pc / halted / error.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q [$];
    logic [63:0] m_pc;
    bit          m_halt;
    bit          m_err;

    function automatic logic [31:0] mem_at(input logic [63:0] a);
        return (a < 64'd128) ? mem[a[6:2]] : NOP;
    endfunction

    function automatic void model_step(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
        if (rst) begin
            m_q.delete();
            m_pc   = RST_PC;
            m_halt = 1'b0;
            m_err  = 1'b0;
            return;
        end
        if (rv) begin
            m_q.delete();
            m_pc   = rpc & ~64'h3;
            m_halt = 1'b0;
            if (rpc[1:0] != 2'b00) m_err = 1'b1;
            return;
        end
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (!m_halt) begin
            if (m_pc >= LIMIT) begin
                m_halt = 1'b1;
            end else if (m_q.size() < 2) begin
                m_q.push_back('{m_pc, mem_at(m_pc)});
                m_pc = m_pc + 64'd4;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit rdy);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = rdy;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        checks++; if (out_pc !== 64'h0) begin failures++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
        checks++; if (out_instruction !== 32'h0) begin failures++; $display("FAIL reset_out_inst got=%h want=0", out_instruction); end
        checks++; if (inst_address !== RST_PC) begin failures++; $display("FAIL reset_inst_address got=%h want=%h", inst_address, RST_PC); end
        checks++; if (misaligned_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", misaligned_err); end
    endtask

    task automatic test_basic_fetch();
        do_reset(1'b1);
        tick();
        checks++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 64'h0, 32'h10000513}) begin
            failures++; $display("FAIL fetch_first got=%0b/%h/%h want=1/0/10000513", out_valid, out_pc, out_instruction); end
        tick();
        checks++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 64'h4, 32'h00500293}) begin
            failures++; $display("FAIL fetch_second got=%0b/%h/%h want=1/4/00500293", out_valid, out_pc, out_instruction); end
        checks++; if (inst_address !== 64'h8) begin failures++; $display("FAIL fetch_addr got=%h want=8", inst_address); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 64'h0, mem[0]}) begin
                failures++; $display("FAIL stall_head cyc=%0d got=%0b/%h/%h want=1/0/%h", i, out_valid, out_pc, out_instruction, mem[0]); end
        end
        checks++; if (inst_address !== 64'h8) begin failures++; $display("FAIL stall_addr got=%h want=8", inst_address); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 64'(k * 4), mem[k]}) begin
                failures++; $display("FAIL drain_head k=%0d got=%0b/%h/%h want=1/%h/%h", k, out_valid, out_pc, out_instruction, 64'(k * 4), mem[k]); end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if ({out_valid, inst_address} !== {1'b0, 64'h40}) begin
            failures++; $display("FAIL redirect_flush got=%0b/%h want=0/40", out_valid, inst_address); end
        tick();
        checks++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 64'h40, 32'h000fa403}) begin
            failures++; $display("FAIL redirect_head got=%0b/%h/%h want=1/40/000fa403", out_valid, out_pc, out_instruction); end
    endtask

    task automatic test_halt();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h50;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 64'h50 + 64'(k * 4), mem[20 + k]}) begin
                failures++; $display("FAIL halt_head k=%0d got=%0b/%h/%h want=1/%h/%h", k, out_valid, out_pc, out_instruction, 64'h50 + 64'(k * 4), mem[20 + k]); end
        end
        repeat (4) tick();
        checks++; if ({out_valid, inst_address} !== {1'b0, 64'h60}) begin
            failures++; $display("FAIL halt_drained got=%0b/%h want=0/60", out_valid, inst_address); end
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        tick();
        redirect_valid = 1'b0;
        checks++; if ({out_valid, inst_address} !== {1'b0, 64'h0}) begin
            failures++; $display("FAIL halt_restart got=%0b/%h want=0/0", out_valid, inst_address); end
        tick();
        checks++; if ({out_valid, out_pc, out_instruction} !== {1'b1, 64'h0, mem[0]}) begin
            failures++; $display("FAIL halt_resume got=%0b/%h/%h want=1/0/%h", out_valid, out_pc, out_instruction, mem[0]); end
    endtask

    task automatic test_misaligned();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h42;
        tick();
        redirect_valid = 1'b0;
        checks++; if ({inst_address, misaligned_err} !== {64'h40, 1'b1}) begin
            failures++; $display("FAIL misaligned_set got=%h/%0b want=40/1", inst_address, misaligned_err); end
        repeat (10) tick();
        checks++; if (misaligned_err !== 1'b1) begin failures++; $display("FAIL misaligned_sticky got=%0b want=1", misaligned_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (misaligned_err !== 1'b0) begin failures++; $display("FAIL misaligned_clear got=%0b want=0", misaligned_err); end
    endtask

    task automatic test_reset_override();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h46;
        tick();
        redirect_valid = 1'b0;
        repeat (3) tick();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h41;
        out_ready      = 1'b1;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        checks++; if ({out_valid, out_pc, inst_address, misaligned_err} !== {1'b0, 64'h0, RST_PC, 1'b0}) begin
            failures++; $display("FAIL reset_override got=%0b/%h/%h/%0b want=0/0/%h/0", out_valid, out_pc, inst_address, misaligned_err, RST_PC); end
    endtask

    task automatic test_random();
        logic [63:0]  rpc;
        logic         e_valid;
        logic [63:0]  e_pc;
        logic [31:0]  e_inst;
        int           shown = 0;
        do_reset(1'b1);
        model_step(1'b1, 1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 1500; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            rpc            = 64'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 7) == 0) rpc = rpc + 64'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFFC;
            redirect_pc    = rpc;
            out_ready      = ($urandom_range(0, 3) != 0);
            model_step(reset, redirect_valid, redirect_pc, out_ready);
            tick();
            e_valid = (m_q.size() > 0);
            e_pc    = e_valid ? m_q[0].pc : 64'h0;
            e_inst  = e_valid ? m_q[0].inst : 32'h0;
            checks++;
            if ({out_valid, out_pc, out_instruction, inst_address, misaligned_err} !== {e_valid, e_pc, e_inst, m_pc, m_err}) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc=%0d got=%0b/%h/%h/%h/%0b want=%0b/%h/%h/%h/%0b", i,
                             out_valid, out_pc, out_instruction, inst_address, misaligned_err,
                             e_valid, e_pc, e_inst, m_pc, m_err);
                end
            end
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0]  = 32'h10000513;
        mem[1]  = 32'h00500293;
        mem[16] = 32'h000fa403;

        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect();
        test_halt();
        test_misaligned();
        test_reset_override();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
